// File: rtl/gnr_node_n.sv
// Multi-copy state node: each copy loads apc on every eff-th start strobe,
// flags value changes and keeps a saturating count of applied updates.
module gnr_node_n #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned NCOPY    = 2,
  parameter int unsigned STRIDE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reset_nos,
  input  logic [WIDTH-1:0]          init_state,
  input  logic [NCOPY-1:0]          start,
  input  logic [NCOPY*STRIDE_W-1:0] stride,
  input  logic [NCOPY*WIDTH-1:0]    apc,
  output logic [NCOPY*WIDTH-1:0]    s,
  output logic [NCOPY*WIDTH-1:0]    icos,
  output logic [NCOPY-1:0]          changed,
  output logic [NCOPY*16-1:0]       upd_cnt
);

  localparam int unsigned CNT_W = 16;

  logic [NCOPY*WIDTH-1:0]    s_q, s_d;
  logic [NCOPY*STRIDE_W-1:0] skip_q, skip_d;
  logic [NCOPY-1:0]          chg_q, chg_d;
  logic [NCOPY*CNT_W-1:0]    cnt_q, cnt_d;

  // Per-copy next state; reset_nos outranks start, stride is sampled only on an applied update.
  always_comb begin
    s_d    = s_q;
    skip_d = skip_q;
    chg_d  = '0;
    cnt_d  = cnt_q;
    if (reset_nos) begin
      for (int k = 0; k < int'(NCOPY); k++) begin
        s_d[k*WIDTH +: WIDTH] = init_state;
      end
      skip_d = '0;
      cnt_d  = '0;
    end else begin
      for (int k = 0; k < int'(NCOPY); k++) begin
        if (start[k]) begin
          if (skip_q[k*STRIDE_W +: STRIDE_W] == '0) begin
            s_d[k*WIDTH +: WIDTH] = apc[k*WIDTH +: WIDTH];
            chg_d[k] = (apc[k*WIDTH +: WIDTH] != s_q[k*WIDTH +: WIDTH]);
            // A zero stride behaves as one, so the reload value is max(stride,1)-1.
            if (stride[k*STRIDE_W +: STRIDE_W] == '0) begin
              skip_d[k*STRIDE_W +: STRIDE_W] = '0;
            end else begin
              skip_d[k*STRIDE_W +: STRIDE_W] =
                stride[k*STRIDE_W +: STRIDE_W] - STRIDE_W'(1);
            end
            if (cnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
              cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
          end else begin
            skip_d[k*STRIDE_W +: STRIDE_W] =
              skip_q[k*STRIDE_W +: STRIDE_W] - STRIDE_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      skip_q <= '0;
      chg_q  <= '0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      skip_q <= skip_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s       = s_q;
  assign icos    = s_q;
  assign changed = chg_q;
  assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_gnr_node_n.sv
// Directed table-driven bench for gnr_node_n (WIDTH=1, NCOPY=2, STRIDE_W=4),
// plus a long saturation sequence for the update counter.
module tb_gnr_node_n;

  logic       clk = 1'b0;
  logic       rst, reset_nos;
  logic [0:0] init_state;
  logic [1:0] start;
  logic [7:0] stride;
  logic [1:0] apc;
  logic [1:0] s, icos, changed;
  logic [31:0] upd_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  gnr_node_n #(.WIDTH(1), .NCOPY(2), .STRIDE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start      (start),
    .stride     (stride),
    .apc        (apc),
    .s          (s),
    .icos       (icos),
    .changed    (changed),
    .upd_cnt    (upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rn;
    logic        init;
    logic [1:0]  start;
    logic [7:0]  stride;
    logic [1:0]  apc;
    logic [1:0]  es;
    logic [1:0]  ech;
    logic [15:0] ec0;
    logic [15:0] ec1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rn, input logic init,
                     input logic [1:0] st, input logic [7:0] strd,
                     input logic [1:0] a, input logic [1:0] es,
                     input logic [1:0] ech, input logic [15:0] ec0,
                     input logic [15:0] ec1);
    vec_t v;
    v.rst = r; v.rn = rn; v.init = init; v.start = st; v.stride = strd;
    v.apc = a; v.es = es; v.ech = ech; v.ec0 = ec0; v.ec1 = ec1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rn, input logic init,
                       input logic [1:0] st, input logic [7:0] strd,
                       input logic [1:0] a);
    rst = r; reset_nos = rn; init_state = init; start = st; stride = strd; apc = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; reset_nos = 1'b0; init_state = 1'b0;
    start = '0; stride = '0; apc = '0;

    //  rst rn ini start stride  apc   s     chg   cnt0   cnt1
    add(1, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0);
    // copy0 stride 1, copy1 stride 2, four starts with apc=0
    add(0, 1, 1, 2'b00, 8'h21, 2'b00, 2'b11, 2'b00, 16'd0, 16'd0);
    add(0, 0, 0, 2'b11, 8'h21, 2'b00, 2'b00, 2'b11, 16'd1, 16'd1);
    add(0, 0, 0, 2'b11, 8'h21, 2'b00, 2'b00, 2'b00, 16'd2, 16'd1);
    add(0, 0, 0, 2'b11, 8'h21, 2'b00, 2'b00, 2'b00, 16'd3, 16'd2);
    add(0, 0, 0, 2'b11, 8'h21, 2'b00, 2'b00, 2'b00, 16'd4, 16'd2);
    add(0, 0, 0, 2'b00, 8'h21, 2'b00, 2'b00, 2'b00, 16'd4, 16'd2);
    // stride 0 on copy0 acts as stride 1
    add(0, 0, 0, 2'b01, 8'h10, 2'b01, 2'b01, 2'b01, 16'd5, 16'd2);
    add(0, 0, 0, 2'b01, 8'h10, 2'b00, 2'b00, 2'b01, 16'd6, 16'd2);
    add(0, 0, 0, 2'b01, 8'h10, 2'b01, 2'b01, 2'b01, 16'd7, 16'd2);
    // same value -> no change pulse; different value -> one-cycle pulse
    add(0, 0, 0, 2'b01, 8'h10, 2'b01, 2'b01, 2'b00, 16'd8, 16'd2);
    add(0, 0, 0, 2'b01, 8'h10, 2'b00, 2'b00, 2'b01, 16'd9, 16'd2);
    add(0, 0, 0, 2'b00, 8'h10, 2'b00, 2'b00, 2'b00, 16'd9, 16'd2);
    add(0, 0, 0, 2'b10, 8'h10, 2'b10, 2'b10, 2'b10, 16'd9, 16'd3);
    // rst overrides reset_nos and start
    add(1, 1, 1, 2'b11, 8'h10, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0);
    // first start after rst applies at once; reset_nos abandons partial stride
    add(0, 0, 0, 2'b11, 8'h33, 2'b11, 2'b11, 2'b11, 16'd1, 16'd1);
    add(0, 0, 0, 2'b11, 8'h33, 2'b00, 2'b11, 2'b00, 16'd1, 16'd1);
    add(0, 1, 0, 2'b11, 8'h33, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0);
    add(0, 0, 0, 2'b11, 8'h33, 2'b11, 2'b11, 2'b11, 16'd1, 16'd1);
    // stride changed 3->1 mid-count: next update still lands on 4th start
    add(0, 0, 0, 2'b11, 8'h11, 2'b00, 2'b11, 2'b00, 16'd1, 16'd1);
    add(0, 0, 0, 2'b11, 8'h11, 2'b00, 2'b11, 2'b00, 16'd1, 16'd1);
    add(0, 0, 0, 2'b11, 8'h11, 2'b00, 2'b00, 2'b11, 16'd2, 16'd2);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rn, vecs[i].init, vecs[i].start,
            vecs[i].stride, vecs[i].apc);
      chk("s",       i, 32'(s),             32'(vecs[i].es));
      chk("icos",    i, 32'(icos),          32'(vecs[i].es));
      chk("changed", i, 32'(changed),       32'(vecs[i].ech));
      chk("upd_cnt0", i, 32'(upd_cnt[15:0]),  32'(vecs[i].ec0));
      chk("upd_cnt1", i, 32'(upd_cnt[31:16]), 32'(vecs[i].ec1));
    end

    // Saturation: 65535 updates on copy0 only reach FFFF, further ones hold it
    drive(0, 1, 0, 2'b00, 8'h11, 2'b00);
    for (int n = 0; n < 65535; n++) begin
      drive(0, 0, 0, 2'b01, 8'h11, 2'(n & 1));
    end
    chk("sat_reach", 100, 32'(upd_cnt[15:0]), 32'h0000_FFFF);
    chk("sat_other", 100, 32'(upd_cnt[31:16]), 32'h0);
    drive(0, 0, 0, 2'b01, 8'h11, 2'b01);
    drive(0, 0, 0, 2'b01, 8'h11, 2'b00);
    chk("sat_hold", 101, 32'(upd_cnt[15:0]), 32'h0000_FFFF);
    chk("sat_s",    101, 32'(s), 32'h0);
    drive(0, 0, 0, 2'b00, 8'h11, 2'b00);
    chk("sat_idle", 102, 32'(upd_cnt[15:0]), 32'h0000_FFFF);
    chk("sat_chg",  102, 32'(changed), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
